// File: rtl/acc_burst_collector_if.sv
// Stream bundle for acc_burst_collector: upstream producer side and downstream FIFO head side.
// The collector connects through the slave modport; the environment uses master.
interface acc_burst_collector_if #(
   parameter int unsigned DATA_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/acc_burst_collector.sv
// Groups accelerator beats into bursts of burst_len, tags the final beat and buffers {last, data}
// in a DEPTH-entry FIFO. Define ACC_BURST_STATS_EN to build the delivered-burst counter.
module acc_burst_collector #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          burst_len,
   acc_burst_collector_if.slave bus,
   output logic                 busy,
   output logic [31:0]          burst_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [0:0] {
      StIdle,
      StActive
   } state_e;

   state_e      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [15:0] len_q, len_d;
   logic [15:0] beat_q, beat_d;
   logic [15:0] eff_len;

   logic [DATA_W:0] mem_q [DEPTH];
   logic [DATA_W:0] head;

   logic full, empty, push, pop, push_last;

   // Extra MSB on the pointers separates full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign bus.in_ready  = rst_n & ~full;
   assign bus.out_valid = rst_n & ~empty;
   assign bus.out_data  = head[DATA_W-1:0];
   assign bus.out_last  = bus.out_valid & head[DATA_W];

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;
   assign busy = rst_n & ((state_q == StActive) | ~empty);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      beat_d    = beat_q;
      push_last = 1'b0;
      eff_len   = (burst_len == 16'd0) ? 16'd1 : burst_len;
      unique case (state_q)
         StIdle: begin
            if (push) begin
               len_d  = eff_len;
               beat_d = 16'd1;
               if (eff_len == 16'd1) begin
                  push_last = 1'b1;
               end else begin
                  state_d = StActive;
               end
            end
         end
         StActive: begin
            if (push) begin
               beat_d = beat_q + 16'd1;
               if (beat_d == len_q) begin
                  push_last = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= 16'd1;
         beat_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
      end
   end

   // Storage is not reset; entries are only observed once the write pointer has passed them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {push_last, bus.in_data};
      end
   end

`ifdef ACC_BURST_STATS_EN
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (pop && head[DATA_W]) count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign burst_count = count_q;
`else
   assign burst_count = 32'd0;
`endif
endmodule

// File: tb/tb_acc_burst_collector.sv
// Self-checking bench for acc_burst_collector: directed burst scenarios plus randomized traffic
// compared cycle by cycle against a queue-based burst model.
module tb_acc_burst_collector;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] burst_len;
   logic        busy;
   logic [31:0] burst_count;

   acc_burst_collector_if #(.DATA_W(DATA_W)) bus ();

   acc_burst_collector #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .burst_len   (burst_len),
      .bus         (bus),
      .busy        (busy),
      .burst_count (burst_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t       model_q [$];
   int          model_rem  = 0;
   logic [31:0] model_cnt  = 32'd0;
   int          n_checks   = 0;
   int          n_errors   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef ACC_BURST_STATS_EN
      return model_cnt;
`else
      return 32'd0;
`endif
   endfunction

   // One clock: drive inputs, compare outputs against the model, then advance the model.
   task automatic step(input logic v, input logic [63:0] d, input logic r,
                       input logic [15:0] len, input logic rst);
      logic  exp_ready, exp_ov, exp_busy, do_push, do_pop;
      beat_t b;
      @(negedge clk);
      rst_n         = rst;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      burst_len     = len;
      #1;
      exp_ready = rst && (model_q.size() < DEPTH);
      exp_ov    = rst && (model_q.size() > 0);
      exp_busy  = rst && ((model_rem > 0) || (model_q.size() > 0));
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      check("busy", 64'(busy), 64'(exp_busy));
      check("burst_count", 64'(burst_count), 64'(exp_count()));
      if (exp_ov) begin
         check("out_data", bus.out_data, model_q[0].data);
         check("out_last", 64'(bus.out_last), 64'(model_q[0].last));
      end else begin
         check("out_last_idle", 64'(bus.out_last), 64'd0);
      end
      do_push = v && exp_ready;
      do_pop  = r && exp_ov;
      @(posedge clk);
      if (!rst) begin
         model_q.delete();
         model_rem = 0;
         model_cnt = 32'd0;
      end else begin
         if (do_pop) begin
            b = model_q.pop_front();
            if (b.last) model_cnt = model_cnt + 32'd1;
         end
         if (do_push) begin
            if (model_rem == 0) model_rem = (len == 16'd0) ? 1 : int'(len);
            model_rem--;
            b.data = d;
            b.last = (model_rem == 0);
            model_q.push_back(b);
         end
      end
   endtask

   task automatic idle(input int n, input logic r, input logic [15:0] len);
      for (int i = 0; i < n; i++) step(1'b0, 64'd0, r, len, 1'b1);
   endtask

   task automatic reset_cycle(input logic [15:0] len);
      step(1'b0, 64'd0, 1'b0, len, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      burst_len     = 16'd4;

      reset_cycle(16'd4);
      reset_cycle(16'd4);
      idle(1, 1'b0, 16'd4);

      // Burst of 4, eight back-to-back beats drained immediately.
      for (int i = 0; i < 8; i++) step(1'b1, 64'(i), 1'b1, 16'd4, 1'b1);
      idle(2, 1'b1, 16'd4);
`ifdef ACC_BURST_STATS_EN
      check("req034_count", 64'(burst_count), 64'd2);
`else
      check("req034_count", 64'(burst_count), 64'd0);
`endif

      // Fill with out_ready low, then drain.
      reset_cycle(16'd4);
      for (int i = 0; i < 10; i++) step(1'b1, 64'(100 + i), 1'b0, 16'd4, 1'b1);
      check("req035_full_ready", 64'(bus.in_ready), 64'd0);
      idle(10, 1'b1, 16'd4);

      // burst_len 0 behaves as single-beat bursts.
      reset_cycle(16'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 64'(200 + i), 1'b1, 16'd0, 1'b1);
      idle(2, 1'b1, 16'd0);
`ifdef ACC_BURST_STATS_EN
      check("req036_count", 64'(burst_count), 64'd3);
`else
      check("req036_count", 64'(burst_count), 64'd0);
`endif

      // Length change mid-burst only affects the next burst.
      reset_cycle(16'd3);
      step(1'b1, 64'd300, 1'b1, 16'd3, 1'b1);
      for (int i = 1; i < 8; i++) step(1'b1, 64'(300 + i), 1'b1, 16'd5, 1'b1);
      idle(2, 1'b1, 16'd5);

      // Reset mid-burst discards the partial burst.
      reset_cycle(16'd4);
      step(1'b1, 64'd400, 1'b0, 16'd4, 1'b1);
      step(1'b1, 64'd401, 1'b0, 16'd4, 1'b1);
      reset_cycle(16'd4);
      for (int i = 0; i < 4; i++) step(1'b1, 64'(410 + i), 1'b1, 16'd4, 1'b1);
      idle(2, 1'b1, 16'd4);

      // Full FIFO with simultaneous push attempt and pop.
      reset_cycle(16'd2);
      for (int i = 0; i < 8; i++) step(1'b1, 64'(500 + i), 1'b0, 16'd2, 1'b1);
      step(1'b1, 64'd600, 1'b1, 16'd2, 1'b1);
      step(1'b1, 64'd601, 1'b0, 16'd2, 1'b1);
      idle(10, 1'b1, 16'd2);

      // Randomized traffic with occasional resets and length changes.
      begin
         logic [15:0] len;
         int          vbias, rbias;
         len   = 16'd3;
         vbias = 2;
         rbias = 2;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
               vbias = $urandom_range(0, 3);
               rbias = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 15) == 0) len = 16'($urandom_range(0, 6));
            step($urandom_range(0, 3) < vbias + 1, {$urandom, $urandom},
                 $urandom_range(0, 3) < rbias + 1, len, $urandom_range(0, 299) != 0);
         end
      end
      idle(12, 1'b1, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/acc_burst_collector.md
ACC_BURST_COLLECTOR -- requirements
Module: acc_burst_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of accelerator data word.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port burst_len  input  16  beats per burst; 0 treated as 1.
REQ-006 SHALL have port in_valid  input  1  upstream accelerator producer valid.
REQ-007 SHALL have port in_ready  output  1  accept indication to upstream.
REQ-008 SHALL have port in_data  input  DATA_W  upstream data word.
REQ-009 SHALL have port out_valid  output  1  downstream word valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  DATA_W  FIFO head word.
REQ-012 SHALL have port out_last  output  1  head word is final beat of its burst.
REQ-013 SHALL have port busy  output  1  burst open or FIFO non-empty.
REQ-014 SHALL have port burst_count  output  32  completed bursts delivered downstream.

Function
REQ-015 SHALL accept a beat when in_valid & in_ready; SHALL write {last, data} into the FIFO tail the same edge.
REQ-016 SHALL drive in_ready = !full; no push-while-full bypass, even if a pop occurs that cycle.
REQ-017 SHALL drive out_valid = !empty, out_data/out_last from the FIFO head; pop on out_valid & out_ready.
REQ-018 SHALL give 1-cycle latency: word accepted at edge N is visible at output after edge N.
REQ-019 SHALL support simultaneous push and pop when neither full nor empty; occupancy unchanged.
REQ-020 SHALL implement FSM S_IDLE (no burst open) and S_ACTIVE (burst open).
REQ-021 S_IDLE: on accepted beat, SHALL latch len_r = max(burst_len,1), set beat counter to 1, go S_ACTIVE; if len_r==1, tag last and stay S_IDLE.
REQ-022 S_ACTIVE: on accepted beat, SHALL increment beat counter; beat with counter == len_r SHALL be tagged last and return FSM to S_IDLE.
REQ-023 SHALL ignore burst_len changes while S_ACTIVE; new value takes effect on next burst's first beat.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH, with an extra wrap bit distinguishing full from empty.
REQ-025 SHALL drive busy = (state==S_ACTIVE) | !empty.
REQ-026 SHALL increment burst_count by 1 when a word with out_last pops; wraps at 2^32-1 to 0.
REQ-027 SHALL hold out_data/out_last stable while out_valid & !out_ready.

Reset
REQ-028 On rst_n low at a clock edge SHALL set state S_IDLE, pointers 0, beat counter 0, len_r 1, burst_count 0.
REQ-029 During and after reset SHALL drive out_valid 0, out_last 0, busy 0, in_ready 1 (0 while rst_n low).
REQ-030 Reset mid-burst SHALL discard FIFO contents and partial burst; no last tag is emitted for it.
REQ-031 FIFO storage array SHALL NOT require reset; out_data is don't-care while out_valid is 0.

Configuration
REQ-032 Macro ACC_BURST_STATS_EN SHALL, when defined, compile in the burst_count counter per REQ-026.
REQ-033 Without ACC_BURST_STATS_EN, burst_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-034 burst_len=4, out_ready=1, 8 back-to-back beats 0..7 -> outputs 0..7 in order, out_last on 3 and 7, burst_count=2.
REQ-035 DEPTH=8, out_ready=0, 10 beats offered -> 8 accepted, in_ready low from 8th accept; raising out_ready drains all 8 in order.
REQ-036 burst_len=0, 3 beats -> every output word has out_last=1, burst_count=3.
REQ-037 burst_len=3, change to 5 after first beat -> first burst ends on beat 3, next burst ends on beat 8.
REQ-038 burst_len=4, 2 beats accepted, rst_n low 1 cycle -> out_valid 0, busy 0, burst_count 0; next 4 beats form a clean burst with last on 4th.
REQ-039 Full FIFO with out_ready=1 and in_valid=1 for one cycle -> one pop, no push, then push accepted next cycle.
